multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle RV32I core.
- Sequences the shared ALU, the unified instruction/data memory port, the IR, the PC and the register file across FETCH/DECODE/EXECUTE/MEM/WB states.
- Takes `op` from the IR and drives datapath selects and enables. Immediate selection stays in the separate immediate decoder.
- Adds a memory ready handshake, an instructions-retired counter and an optional illegal-opcode trap.

---
 rtl/riscv_ctrl_pkg.sv | 71 +++++++
 rtl/instret_counter.sv | 30 +++
 rtl/multicycle_ctrl.sv | 165 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared control constants for the multicycle RV32I core: opcodes, FSM state
// encoding and datapath select codes. Also used by the immediate decoder.
package riscv_ctrl_pkg;

   // Base opcodes (IR[6:0])
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // FSM state encoding
   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_MEMADR    = 4'd2;
   localparam logic [3:0] S_MEMREAD   = 4'd3;
   localparam logic [3:0] S_MEMWB     = 4'd4;
   localparam logic [3:0] S_MEMWRITE  = 4'd5;
   localparam logic [3:0] S_EXECUTER  = 4'd6;
   localparam logic [3:0] S_EXECUTEI  = 4'd7;
   localparam logic [3:0] S_ALUWB     = 4'd8;
   localparam logic [3:0] S_BEQ       = 4'd9;
   localparam logic [3:0] S_JAL       = 4'd10;
   localparam logic [3:0] S_JALR_ADDR = 4'd11;
   localparam logic [3:0] S_JALR_JUMP = 4'd12;
   localparam logic [3:0] S_LUI       = 4'd13;
   localparam logic [3:0] S_ILLEGAL   = 4'd14;

   // ResultSrc
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // ALUSrcA
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   // ALUSrcB
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // ALUOp
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // State that follows DECODE for a given opcode
   function automatic logic [3:0] decode_state(input logic [6:0] op);
      logic [3:0] s;
      case (op)
         OP_LOAD, OP_STORE: s = S_MEMADR;
         OP_RTYPE:          s = S_EXECUTER;
         OP_ITYPE:          s = S_EXECUTEI;
         OP_BRANCH:         s = S_BEQ;
         OP_JAL:            s = S_JAL;
         OP_JALR:           s = S_JALR_ADDR;
         OP_LUI:            s = S_LUI;
         OP_AUIPC:          s = S_ALUWB;
         default:           s = S_ILLEGAL;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/instret_counter.sv
// Retired-instruction counter. Counts one per retire cycle and wraps modulo
// 2^CNT_W; the retire pulse is passed out in the same cycle it is counted.
module instret_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             retire,
   output logic             instr_retired,
   output logic [CNT_W-1:0] instret
);

   logic [CNT_W-1:0] count;

   // Count on each retire edge, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (retire) begin
         count <= count + CNT_W'(1);
      end
   end

   // Pulse is suppressed while reset is held so no stray retire is seen
   always_comb begin
      instr_retired = retire & ~reset;
      instret       = count;
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core. Moore outputs decoded from
// state; IRWrite, FETCH's PCUpdate and MemWrite are qualified by mem_ready.
// Build option: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN makes ILLEGAL a sticky halt
// with illegal_instr=1; otherwise ILLEGAL is a one-cycle retiring NOP.
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       op,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             AdrSrc,
   output logic             IRWrite,
   output logic             PCUpdate,
   output logic             Branch,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic             instr_retired,
   output logic [CNT_W-1:0] instret,
   output logic             illegal_instr
);

   import riscv_ctrl_pkg::*;

   logic [3:0] state;
   logic [3:0] state_next;
   logic       retire;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Next state; retire marks the last cycle of each instruction
   always_comb begin
      state_next = state;
      retire     = 1'b0;
      case (state)
         S_FETCH:     if (mem_ready) state_next = S_DECODE;
         S_DECODE:    state_next = decode_state(op);
         S_MEMADR:    state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:   if (mem_ready) state_next = S_MEMWB;
         S_MEMWRITE: begin
            if (mem_ready) begin
               state_next = S_FETCH;
               retire     = 1'b1;
            end
         end
         S_MEMWB, S_ALUWB, S_BEQ: begin
            state_next = S_FETCH;
            retire     = 1'b1;
         end
         S_EXECUTER, S_EXECUTEI, S_JAL, S_LUI, S_JALR_JUMP: state_next = S_ALUWB;
         S_JALR_ADDR: state_next = S_JALR_JUMP;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
         S_ILLEGAL:   state_next = S_ILLEGAL;
`else
         S_ILLEGAL: begin
            state_next = S_FETCH;
            retire     = 1'b1;
         end
`endif
         default:     state_next = S_FETCH;
      endcase
   end

   // Datapath controls; everything forced low while reset is held
   always_comb begin
      mem_req   = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      PCUpdate  = 1'b0;
      Branch    = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      ALUOp     = ALU_ADD;
      if (!reset) begin
         case (state)
            S_FETCH: begin
               mem_req   = 1'b1;
               ALUSrcB   = SRCB_FOUR;
               ResultSrc = RES_ALURESULT;
               IRWrite   = mem_ready;
               PCUpdate  = mem_ready;
            end
            S_DECODE: begin
               ALUSrcA = SRCA_OLDPC;
               ALUSrcB = SRCB_IMM;
            end
            S_MEMADR, S_JALR_ADDR: begin
               ALUSrcA = SRCA_RS1;
               ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
               mem_req = 1'b1;
               AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
               ResultSrc = RES_DATA;
               RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
               mem_req  = 1'b1;
               AdrSrc   = 1'b1;
               MemWrite = mem_ready;
            end
            S_EXECUTER: begin
               ALUSrcA = SRCA_RS1;
               ALUOp   = ALU_FUNCT;
            end
            S_EXECUTEI: begin
               ALUSrcA = SRCA_RS1;
               ALUSrcB = SRCB_IMM;
               ALUOp   = ALU_FUNCT;
            end
            S_ALUWB:  RegWrite = 1'b1;
            S_BEQ: begin
               ALUSrcA = SRCA_RS1;
               ALUOp   = ALU_SUB;
               Branch  = 1'b1;
            end
            S_JAL, S_JALR_JUMP: begin
               ALUSrcA  = SRCA_OLDPC;
               ALUSrcB  = SRCB_FOUR;
               PCUpdate = 1'b1;
            end
            S_LUI: begin
               ALUSrcA = SRCA_ZERO;
               ALUSrcB = SRCB_IMM;
            end
            default: ;
         endcase
      end
   end

   // Trap indicator
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
   always_comb illegal_instr = (state == S_ILLEGAL) & ~reset;
`else
   always_comb illegal_instr = 1'b0;
`endif

   instret_counter #(
      .CNT_W(CNT_W)
   ) u_instret_counter (
      .clk           (clk),
      .reset         (reset),
      .retire        (retire),
      .instr_retired (instr_retired),
      .instret       (instret)
   );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl (CNT_W=8). Expected per-cycle
// outputs are built from per-instruction step lists with random wait states.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] op = 7'd0;
   logic       mem_ready = 1'b0;
   logic       mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
   logic       instr_retired, illegal_instr;
   logic [7:0] instret;

   int         n_assert = 0;
   int         n_fail = 0;
   logic [7:0] cnt_model = 8'd0;
   logic [16:0] obs;

   multicycle_ctrl #(.CNT_W(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .op            (op),
      .mem_ready     (mem_ready),
      .mem_req       (mem_req),
      .AdrSrc        (AdrSrc),
      .IRWrite       (IRWrite),
      .PCUpdate      (PCUpdate),
      .Branch        (Branch),
      .RegWrite      (RegWrite),
      .MemWrite      (MemWrite),
      .ResultSrc     (ResultSrc),
      .ALUSrcA       (ALUSrcA),
      .ALUSrcB       (ALUSrcB),
      .ALUOp         (ALUOp),
      .instr_retired (instr_retired),
      .instret       (instret),
      .illegal_instr (illegal_instr)
   );

   always #5 clk = ~clk;

   // {mem_req,AdrSrc,IRWrite,PCUpdate,Branch,RegWrite,MemWrite,ResultSrc,A,B,ALUOp,ret,ill}
   assign obs = {mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUOp, instr_retired, illegal_instr};

   // en = {mem_req,AdrSrc,IRWrite,PCUpdate,Branch,RegWrite,MemWrite}, fl = {ret,ill}
   function automatic logic [16:0] mk(input logic [6:0] en, input logic [1:0] rs,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] alu, input logic [1:0] fl);
      return {en, rs, a, b, alu, fl};
   endfunction

   function automatic logic rbit();
      return 1'($urandom);
   endfunction

   function automatic logic [6:0] op_of(input int cls);
      logic [6:0] o;
      case (cls)
         0: o = 7'b0000011;
         1: o = 7'b0100011;
         2: o = 7'b0110011;
         3: o = 7'b0010011;
         4: o = 7'b1100011;
         5: o = 7'b1101111;
         6: o = 7'b1100111;
         7: o = 7'b0110111;
         8: o = 7'b0010111;
         default: o = 7'b1111111;
      endcase
      return o;
   endfunction

   // One clock cycle: drive mem_ready, check outputs and counter mid-cycle
   task automatic step(input string tag, input logic [16:0] exp, input logic rdy);
      @(negedge clk);
      mem_ready = rdy;
      #1;
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: outputs got %b expected %b", tag, obs, exp);
      end
      n_assert++;
      assert (instret === cnt_model) else begin
         n_fail++;
         $error("FAIL %s_instret: got %0d expected %0d", tag, instret, cnt_model);
      end
      if (exp[1]) cnt_model = cnt_model + 8'd1;
   endtask

   task automatic chk_instret(input string tag, input logic [7:0] exp);
      @(posedge clk);
      #1;
      n_assert++;
      assert (instret === exp) else begin
         n_fail++;
         $error("FAIL %s: instret got %0d expected %0d", tag, instret, exp);
      end
   endtask

   // Asynchronous reset mid-cycle; outputs must drop at once and stay low
   task automatic do_reset(input string tag);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      n_assert++;
      assert (obs === 17'd0 && instret === 8'd0) else begin
         n_fail++;
         $error("FAIL %s_async: outputs %b instret %0d expected 0/0", tag, obs, instret);
      end
      cnt_model = 8'd0;
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      n_assert++;
      assert (obs === 17'd0 && instret === 8'd0) else begin
         n_fail++;
         $error("FAIL %s_held: outputs %b instret %0d expected 0/0", tag, obs, instret);
      end
      mem_ready = 1'b0;
      reset = 1'b0;
   endtask

   task automatic fetch_decode(input int wf);
      for (int i = 0; i < wf; i++)
         step("fetch_wait", mk(7'b1000000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00), 1'b0);
      step("fetch", mk(7'b1011000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00), 1'b1);
      step("decode", mk(7'b0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00), rbit());
   endtask

   task automatic aluwb();
      step("aluwb", mk(7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10), rbit());
   endtask

   task automatic run_instr(input int cls, input int wf, input int wm);
      op = op_of(cls);
      fetch_decode(wf);
      case (cls)
         0: begin
            step("memadr", mk(7'b0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00), rbit());
            for (int i = 0; i < wm; i++)
               step("memread_wait", mk(7'b1100000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), 1'b0);
            step("memread", mk(7'b1100000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), 1'b1);
            step("memwb", mk(7'b0000010, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10), rbit());
         end
         1: begin
            step("memadr", mk(7'b0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00), rbit());
            for (int i = 0; i < wm; i++)
               step("memwrite_wait", mk(7'b1100000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), 1'b0);
            step("memwrite", mk(7'b1100001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10), 1'b1);
         end
         2: begin
            step("execr", mk(7'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00), rbit());
            aluwb();
         end
         3: begin
            step("execi", mk(7'b0, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00), rbit());
            aluwb();
         end
         4: step("beq", mk(7'b0000100, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10), rbit());
         5: begin
            step("jal", mk(7'b0001000, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00), rbit());
            aluwb();
         end
         6: begin
            step("jalr_addr", mk(7'b0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00), rbit());
            step("jalr_jump", mk(7'b0001000, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00), rbit());
            aluwb();
         end
         7: begin
            step("lui", mk(7'b0, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00), rbit());
            aluwb();
         end
         8: aluwb();
         default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            for (int i = 0; i < 100; i++)
               step("illegal_hold", mk(7'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01), rbit());
`else
            step("illegal_nop", mk(7'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10), rbit());
`endif
         end
      endcase
   endtask

   initial begin
      do_reset("reset");

      // lw, no wait states
      run_instr(0, 0, 0);
      chk_instret("lw_count", 8'd1);

      // sw with three wait cycles in MEMWRITE
      run_instr(1, 0, 3);
      chk_instret("sw_count", 8'd2);

      // jalr then beq back to back
      run_instr(6, 0, 0);
      run_instr(4, 0, 0);
      chk_instret("jalr_beq_count", 8'd4);

      // Reset while a lw is waiting in MEMREAD
      op = op_of(0);
      fetch_decode(1);
      step("memadr", mk(7'b0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00), 1'b1);
      step("memread_wait", mk(7'b1100000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), 1'b0);
      step("memread_wait", mk(7'b1100000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), 1'b0);
      do_reset("reset_memread");
      run_instr(0, 0, 0);
      chk_instret("after_reset_count", 8'd1);

      // Random legal instruction mix with random wait states
      for (int k = 0; k < 40; k++)
         run_instr(int'($urandom_range(8, 0)), int'($urandom_range(2, 0)),
                   int'($urandom_range(2, 0)));

      // Illegal opcode
      run_instr(9, 0, 0);
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      run_instr(8, 0, 0);
`endif
      do_reset("reset_illegal");

      // 256 auipc with CNT_W=8 wraps the counter
      for (int k = 0; k < 255; k++) run_instr(8, 0, 0);
      chk_instret("auipc_255", 8'd255);
      run_instr(8, 0, 0);
      chk_instret("auipc_wrap", 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
